// File: rtl/scan_decoder.sv
// scan_decoder: registered 1-of-2^SEL_W active-low decoder with G1/G2A_N/G2B_N
// enables and an auto-scan mode for multiplexed digit / LED-row driving.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     synchronous reset, active-high, overrides everything
//   g1_i      enable, active-high
//   g2a_n_i   enable, active-low
//   g2b_n_i   enable, active-low
//   mode_i    0 = direct decode of sel_i, 1 = auto-scan 0..last_i
//   sel_i     index used in direct mode
//   div_i     scan step period is div_i+1 clock cycles
//   last_i    highest scanned index; scan wraps to 0 after it
//   y_n_o     decoded outputs, active-low, at most one bit low
//   idx_o     index currently driven
//   valid_o   registered enable; high when one y_n_o bit is low
//   wrap_o    one-cycle pulse coincident with the scan index returning to 0
module scan_decoder #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DIV_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  g1_i,
    input  logic                  g2a_n_i,
    input  logic                  g2b_n_i,
    input  logic                  mode_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [DIV_W-1:0]      div_i,
    input  logic [SEL_W-1:0]      last_i,
    output logic [2**SEL_W-1:0]   y_n_o,
    output logic [SEL_W-1:0]      idx_o,
    output logic                  valid_o,
    output logic                  wrap_o
);

    localparam int unsigned OUTS = 2**SEL_W;

    logic [OUTS-1:0]  y_n_d,   y_n_q;
    logic [SEL_W-1:0] idx_d,   idx_q;
    logic             valid_d, valid_q;
    logic             wrap_d,  wrap_q;
    logic [DIV_W-1:0] cnt_d,   cnt_q;

    logic en;
    logic tick;

    assign en   = g1_i & ~g2a_n_i & ~g2b_n_i;
    // Equality, not >=: if div_i drops below cnt_q the counter rolls over
    // through its maximum without ticking.
    assign tick = (cnt_q == div_i);

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (en) begin
            valid_d = 1'b1;
            if (!mode_i) begin
                idx_d = sel_i;
                cnt_d = '0;
            end else if (tick) begin
                cnt_d = '0;
                // >= so that lowering last_i below idx_q wraps on the next tick
                if (idx_q >= last_i) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // When disabled idx and the divider freeze so a scan resumes seamlessly.

        y_n_d = valid_d ? ~(OUTS'(1) << idx_d) : '1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_n_q   <= '1;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            y_n_q   <= y_n_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y_n_o   = y_n_q;
    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed testbench for scan_decoder (SEL_W = 3, DIV_W = 16).
module tb_scan_decoder;

    logic        clk;
    logic        rst;
    logic        g1, g2a_n, g2b_n, mode;
    logic [2:0]  sel, last;
    logic [15:0] div;
    logic [7:0]  y_n;
    logic [2:0]  idx;
    logic        valid, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    scan_decoder #(.SEL_W(3), .DIV_W(16)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .g1_i    (g1),
        .g2a_n_i (g2a_n),
        .g2b_n_i (g2b_n),
        .mode_i  (mode),
        .sel_i   (sel),
        .div_i   (div),
        .last_i  (last),
        .y_n_o   (y_n),
        .idx_o   (idx),
        .valid_o (valid),
        .wrap_o  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_y, input logic [2:0] e_idx,
                             input logic e_valid, input logic e_wrap);
        check({tag, ".y_n"},   32'(y_n),   32'(e_y));
        check({tag, ".idx"},   32'(idx),   32'(e_idx));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".wrap"},  32'(wrap),  32'(e_wrap));
    endtask

    logic [7:0] exp_y;
    logic [2:0] exp_i;

    initial begin
        // 1. Reset, then direct sweep
        rst = 1'b1; g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
        mode = 1'b0; sel = 3'd5; div = 16'd0; last = 3'd7;
        tick();
        check_out("rst1", 8'hFF, 3'd0, 1'b0, 1'b0);
        tick();
        check_out("rst2", 8'hFF, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            exp_i = 3'(s);
            exp_y = ~(8'b1 << s);
            check_out($sformatf("direct%0d", s), exp_y, exp_i, 1'b1, 1'b0);
            if (s == 5) check("direct5_lit", 32'(y_n), 32'hDF);
        end

        // 2. Enable truth table with sel = 3 (idx frozen at 7 while disabled)
        sel = 3'd3;
        g1 = 1'b0; g2a_n = 1'b0; g2b_n = 1'b0; tick();
        check_out("en000", 8'hFF, 3'd7, 1'b0, 1'b0);
        g1 = 1'b1; g2a_n = 1'b1; g2b_n = 1'b0; tick();
        check_out("en110", 8'hFF, 3'd7, 1'b0, 1'b0);
        g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b1; tick();
        check_out("en101", 8'hFF, 3'd7, 1'b0, 1'b0);
        g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0; tick();
        check_out("en100", 8'hF7, 3'd3, 1'b1, 1'b0);

        // 3. Scan timing: div = 2, last = 7, from idx 0
        sel = 3'd0; tick();
        check_out("scan_pre", 8'hFE, 3'd0, 1'b1, 1'b0);
        mode = 1'b1; div = 16'd2; last = 3'd7;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_i = 3'((k / 3) % 8);
            exp_y = ~(8'b1 << exp_i);
            check_out($sformatf("scan3_%0d", k), exp_y, exp_i, 1'b1, (k == 24));
        end

        // 4. Partial scan, div = 0, last = 3, then last lowered to 1 at idx 3
        div = 16'd0; last = 3'd3;
        tick(); check_out("p1", 8'hFD, 3'd1, 1'b1, 1'b0);
        tick(); check_out("p2", 8'hFB, 3'd2, 1'b1, 1'b0);
        tick(); check_out("p3", 8'hF7, 3'd3, 1'b1, 1'b0);
        tick(); check_out("p4", 8'hFE, 3'd0, 1'b1, 1'b1);
        tick(); check_out("p5", 8'hFD, 3'd1, 1'b1, 1'b0);
        tick(); check_out("p6", 8'hFB, 3'd2, 1'b1, 1'b0);
        tick(); check_out("p7", 8'hF7, 3'd3, 1'b1, 1'b0);
        last = 3'd1;
        tick(); check_out("l1", 8'hFE, 3'd0, 1'b1, 1'b1);
        tick(); check_out("l2", 8'hFD, 3'd1, 1'b1, 1'b0);
        tick(); check_out("l3", 8'hFE, 3'd0, 1'b1, 1'b1);
        tick(); check_out("l4", 8'hFD, 3'd1, 1'b1, 1'b0);
        tick(); check_out("l5", 8'hFE, 3'd0, 1'b1, 1'b1);

        // 5. Freeze and resume: div = 4, reach idx 2 with divider count 1
        div = 16'd4; last = 3'd7;
        for (int k = 0; k < 11; k++) tick();
        check_out("fz_pre", 8'hFB, 3'd2, 1'b1, 1'b0);
        g1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out($sformatf("fz%0d", k), 8'hFF, 3'd2, 1'b0, 1'b0);
        end
        g1 = 1'b1;
        tick(); check_out("rs1", 8'hFB, 3'd2, 1'b1, 1'b0);
        tick(); check_out("rs2", 8'hFB, 3'd2, 1'b1, 1'b0);
        tick(); check_out("rs3", 8'hFB, 3'd2, 1'b1, 1'b0);
        tick(); check_out("rs4", 8'hF7, 3'd3, 1'b1, 1'b0);

        // 6. Reset mid-scan at idx 6
        for (int k = 0; k < 15; k++) tick();
        check_out("pre_rst", 8'hBF, 3'd6, 1'b1, 1'b0);
        rst = 1'b1; tick();
        check_out("mid_rst", 8'hFF, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_out($sformatf("post_rst%0d", k), 8'hFE, 3'd0, 1'b1, 1'b0);
        end
        tick(); check_out("post_rst5", 8'hFD, 3'd1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
